// File: rtl/isp_video_pkg.sv
// Shared encodings for the ISP video test sources: pattern modes, CFA colours
// and the per-bar channel on-masks of the eight-bar colour chart.
package isp_video_pkg;

  localparam logic [1:0] MODE_FLAT  = 2'b00;
  localparam logic [1:0] MODE_RAMP  = 2'b01;
  localparam logic [1:0] MODE_BARS  = 2'b10;
  localparam logic [1:0] MODE_CHECK = 2'b11;

  typedef enum logic [1:0] {
    CFA_B = 2'd0,
    CFA_G = 2'd1,
    CFA_R = 2'd2
  } cfa_e;

  // Bit i is set when the channel is lit in bar i (white..black).
  localparam logic [7:0] BAR_R_ON = 8'b0011_0011;
  localparam logic [7:0] BAR_G_ON = 8'b0000_1111;
  localparam logic [7:0] BAR_B_ON = 8'b0101_0101;

  function automatic cfa_e cfa_of(input logic row_odd, input logic col_odd,
                                  input logic [1:0] mirror);
    logic [1:0] phase;
    phase = {row_odd ^ mirror[1], col_odd ^ mirror[0]};
    case (phase)
      2'b00:   cfa_of = CFA_B;
      2'b11:   cfa_of = CFA_R;
      default: cfa_of = CFA_G;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Sensor-style frame timing: h/v counters and frame FSM. All outputs are
// combinational decodes of the counter state; the caller registers them.
module video_timing_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int HSYNC_W   = 2,
  parameter int H_BACK    = 2,
  parameter int H_FRONT   = 2,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 2,
  parameter int V_FRONT   = 1,
  localparam int XW       = $clog2(IMG_HDISP),
  localparam int YW       = $clog2(IMG_VDISP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          active_o,
  output logic          vsync_o,
  output logic          hsync_o,
  output logic          busy_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);

  localparam int H_TOTAL = HSYNC_W + H_BACK + IMG_HDISP + H_FRONT;
  localparam int HSTART  = HSYNC_W + H_BACK;
  localparam int HEND    = HSTART + IMG_HDISP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VM1     = (V_SYNC > IMG_VDISP) ? V_SYNC : IMG_VDISP;
  localparam int VM2     = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int VMAX    = (VM1 > VM2) ? VM1 : VM2;
  localparam int VW      = $clog2(VMAX + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW-1:0] last_v;
  logic          line_end;
  logic          last_line;

  always_comb begin
    case (state_q)
      ST_VSYNC:  last_v = VW'(V_SYNC - 1);
      ST_VBACK:  last_v = VW'(V_BACK - 1);
      ST_ACTIVE: last_v = VW'(IMG_VDISP - 1);
      ST_VFRONT: last_v = VW'(V_FRONT - 1);
      default:   last_v = '0;
    endcase
  end

  assign line_end  = (h_q == HW'(H_TOTAL - 1));
  assign last_line = (v_q == last_v);

  // A state only ever advances on the final clock of its final line.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    frame_start_o = 1'b0;
    frame_end_o   = 1'b0;
    if (state_q == ST_IDLE) begin
      h_d = '0;
      v_d = '0;
      if (enable_i) begin
        state_d       = ST_VSYNC;
        frame_start_o = 1'b1;
      end
    end else begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        if (last_line) begin
          v_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = (V_BACK == 0) ? ST_ACTIVE : ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: begin
              frame_end_o = 1'b1;
              if (enable_i) begin
                state_d       = ST_VSYNC;
                frame_start_o = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          v_d = v_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign vsync_o  = !(state_q == ST_VSYNC);
  assign hsync_o  = !(busy_o && (h_q < HW'(HSYNC_W)));
  assign active_o = (state_q == ST_ACTIVE) && (h_q >= HW'(HSTART)) && (h_q < HW'(HEND));
  assign x_o      = XW'(h_q - HW'(HSTART));
  assign y_o      = YW'(v_q);

endmodule

// File: rtl/raw_bayer_pattern_gen.sv
// RAW Bayer sensor emulator: frame timing plus flat/ramp/bars/checker patterns
// with mirror-aware CFA phase; every output is registered one clock after the counters.
module raw_bayer_pattern_gen
  import isp_video_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int HSYNC_W   = 2,
  parameter int H_BACK    = 2,
  parameter int H_FRONT   = 2,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 2,
  parameter int V_FRONT   = 1,
  parameter int R_VAL     = 200,
  parameter int G_VAL     = 150,
  parameter int B_VAL     = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [1:0]        mirror,
  output logic              frame_vsync,
  output logic              frame_hsync,
  output logic              frame_href,
  output logic [DATA_W-1:0] img_raw,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int XW    = $clog2(IMG_HDISP);
  localparam int YW    = $clog2(IMG_VDISP);
  localparam int BAR_W = IMG_HDISP / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [DATA_W-1:0] MAXV  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] R_SMP = DATA_W'(R_VAL);
  localparam logic [DATA_W-1:0] G_SMP = DATA_W'(G_VAL);
  localparam logic [DATA_W-1:0] B_SMP = DATA_W'(B_VAL);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active, vs, hs, tg_busy, frame_start, frame_end;

  video_timing_gen #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .HSYNC_W   (HSYNC_W),
    .H_BACK    (H_BACK),
    .H_FRONT   (H_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .V_FRONT   (V_FRONT)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .x_o           (x),
    .y_o           (y),
    .active_o      (active),
    .vsync_o       (vs),
    .hsync_o       (hs),
    .busy_o        (tg_busy),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end)
  );

  // Shadow copies so a frame is rendered with one consistent mode/phase.
  logic [1:0] mode_q, mirror_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_FLAT;
      mirror_q <= 2'b00;
    end else if (frame_start) begin
      mode_q   <= mode;
      mirror_q <= mirror;
    end
  end

  // Bar position tracks x by counting pixels; it re-zeros in every blank gap.
  logic [BPW-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  always_comb begin
    bar_pix_d = '0;
    bar_idx_d = '0;
    if (active) begin
      if (bar_pix_q == BPW'(BAR_W - 1)) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_pix_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  cfa_e              cfa;
  logic              bar_on;
  logic              check_on;
  logic [DATA_W-1:0] raw_d;

  always_comb begin
    cfa      = cfa_of(y[0], x[0], mirror_q);
    check_on = (((x >> 3) ^ XW'(y >> 3)) & XW'(1)) != '0;
    case (cfa)
      CFA_R:   bar_on = BAR_R_ON[bar_idx_q];
      CFA_G:   bar_on = BAR_G_ON[bar_idx_q];
      default: bar_on = BAR_B_ON[bar_idx_q];
    endcase
    raw_d = '0;
    if (active) begin
      case (mode_q)
        MODE_FLAT: begin
          case (cfa)
            CFA_R:   raw_d = R_SMP;
            CFA_G:   raw_d = G_SMP;
            default: raw_d = B_SMP;
          endcase
        end
        MODE_RAMP: raw_d = DATA_W'(x);
        MODE_BARS: raw_d = bar_on ? MAXV : '0;
        default:   raw_d = check_on ? MAXV : '0;
      endcase
    end
  end

  logic              vsync_q, hsync_q, href_q, busy_q;
  logic [DATA_W-1:0] raw_q;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      hsync_q     <= 1'b1;
      href_q      <= 1'b0;
      raw_q       <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q     <= vs;
      hsync_q     <= hs;
      href_q      <= active;
      raw_q       <= raw_d;
      busy_q      <= tg_busy;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_vsync = vsync_q;
  assign frame_hsync = hsync_q;
  assign frame_href  = href_q;
  assign img_raw     = raw_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_raw_bayer_pattern_gen.sv
// Directed bench: 16x4 frames (154 clocks) on an 8-bit and a 10-bit instance
// sharing stimulus; captured lines are compared against hand-worked samples.
module tb_raw_bayer_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [1:0] mirror;

  always #5 clk = ~clk;

  logic        vs8, hs8, href8, busy8;
  logic [7:0]  raw8;
  logic [15:0] fc8;
  logic        vs10, hs10, href10, busy10;
  logic [9:0]  raw10;
  logic [15:0] fc10;

  raw_bayer_pattern_gen #(
    .DATA_W(8), .IMG_HDISP(16), .IMG_VDISP(4), .HSYNC_W(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .R_VAL(200), .G_VAL(150), .B_VAL(100)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .mirror(mirror),
    .frame_vsync(vs8), .frame_hsync(hs8), .frame_href(href8), .img_raw(raw8),
    .frame_cnt(fc8), .busy(busy8)
  );

  raw_bayer_pattern_gen #(
    .DATA_W(10), .IMG_HDISP(16), .IMG_VDISP(4), .HSYNC_W(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .R_VAL(200), .G_VAL(150), .B_VAL(100)
  ) u_dut10 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .mirror(mirror),
    .frame_vsync(vs10), .frame_hsync(hs10), .frame_href(href10), .img_raw(raw10),
    .frame_cnt(fc10), .busy(busy10)
  );

  logic        sel10 = 1'b0;
  logic        cap_vs, cap_hs, cap_href, cap_busy;
  logic [15:0] cap_raw, cap_fc;

  assign cap_vs   = sel10 ? vs10   : vs8;
  assign cap_hs   = sel10 ? hs10   : hs8;
  assign cap_href = sel10 ? href10 : href8;
  assign cap_busy = sel10 ? busy10 : busy8;
  assign cap_raw  = sel10 ? {6'd0, raw10} : {8'd0, raw8};
  assign cap_fc   = sel10 ? fc10   : fc8;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [15:0] pix [4][16];
  int gap, vs_low, hs_low, href_n, lines_n, blank_nz, busy_first;
  logic [15:0] fc_end;

  // Waits (bounded) for VSYNC low, then samples one full 154-clock frame.
  // At sample index chg_at the inputs are replaced, mid-frame.
  task automatic run_frame(input int chg_at, input logic n_en,
                           input logic [1:0] n_mode, input logic [1:0] n_mirror);
    logic seen;
    logic prev;
    int   line, col;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) pix[r][c] = 16'hFFFF;
    gap = 0; vs_low = 0; hs_low = 0; href_n = 0; blank_nz = 0;
    seen = 1'b0; prev = 1'b0; line = 0; col = 0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (!cap_vs) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    check_val("vsync_start_seen", seen, 1);
    if (!seen) return;
    busy_first = cap_busy;
    for (int i = 0; i < 154; i++) begin
      if (i > 0) @(negedge clk);
      if (!cap_vs) vs_low++;
      if (!cap_hs) hs_low++;
      if (cap_href) begin
        href_n++;
        if (line < 4 && col < 16) pix[line][col] = cap_raw;
        col++;
      end else begin
        if (cap_raw != 0) blank_nz++;
        if (prev) begin
          line++;
          col = 0;
        end
      end
      prev = cap_href;
      if (i == chg_at) begin
        enable = n_en;
        mode   = n_mode;
        mirror = n_mirror;
      end
    end
    lines_n = line;
    fc_end  = cap_fc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int idle_vs, idle_href;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = 2'b00;
    mirror = 2'b00;
    repeat (3) @(negedge clk);
    check_val("rst_vsync", vs8, 1);
    check_val("rst_hsync", hs8, 1);
    check_val("rst_href", href8, 0);
    check_val("rst_raw", raw8, 0);
    check_val("rst_fcnt", fc8, 0);
    check_val("rst_busy", busy8, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("idle_busy", busy8, 0);
    check_val("idle_vsync", vs8, 1);

    // Frame 1: flat, mirror 00; mirror change mid-frame must be ignored.
    enable = 1'b1;
    run_frame(10, 1'b1, 2'b00, 2'b11);
    check_val("f1_busy", busy_first, 1);
    check_val("f1_vs_low", vs_low, 22);
    check_val("f1_hs_low", hs_low, 14);
    check_val("f1_href_n", href_n, 64);
    check_val("f1_lines", lines_n, 4);
    check_val("f1_r0x0", pix[0][0], 100);
    check_val("f1_r0x1", pix[0][1], 150);
    check_val("f1_r1x0", pix[1][0], 150);
    check_val("f1_r1x1", pix[1][1], 200);
    check_val("f1_r3x15", pix[3][15], 200);
    check_val("f1_blank_raw", blank_nz, 0);
    check_val("f1_fcnt", fc_end, 1);

    // Frame 2: back-to-back, mirror 11 from the shadow latch.
    run_frame(10, 1'b1, 2'b10, 2'b00);
    check_val("f2_gap", gap, 0);
    check_val("f2_vs_low", vs_low, 22);
    check_val("f2_r0x0", pix[0][0], 200);
    check_val("f2_r0x1", pix[0][1], 150);
    check_val("f2_r1x0", pix[1][0], 150);
    check_val("f2_r1x1", pix[1][1], 100);
    check_val("f2_fcnt", fc_end, 2);

    // Frame 3: colour bars, mirror 00.
    run_frame(100, 1'b1, 2'b01, 2'b00);
    check_val("f3_r0x0", pix[0][0], 255);
    check_val("f3_r0x2", pix[0][2], 0);
    check_val("f3_r0x10", pix[0][10], 0);
    check_val("f3_r0x11", pix[0][11], 0);
    check_val("f3_r1x11", pix[1][11], 255);
    check_val("f3_r1x14", pix[1][14], 0);
    check_val("f3_r1x15", pix[1][15], 0);
    check_val("f3_fcnt", fc_end, 3);

    // Frame 4: ramp on the 10-bit instance; enable and mode drop in active line 2.
    sel10 = 1'b1;
    run_frame(88, 1'b0, 2'b00, 2'b00);
    check_val("f4_r0x0", pix[0][0], 0);
    check_val("f4_r0x15", pix[0][15], 15);
    check_val("f4_r2x3", pix[2][3], 3);
    check_val("f4_r3x15", pix[3][15], 15);
    check_val("f4_lines", lines_n, 4);
    check_val("f4_blank_raw", blank_nz, 0);
    check_val("f4_fcnt", fc_end, 4);
    repeat (3) @(negedge clk);
    check_val("f4_busy_after", cap_busy, 0);
    idle_vs = 0;
    idle_href = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cap_vs) idle_vs++;
      if (cap_href) idle_href++;
    end
    check_val("idle_vs_low", idle_vs, 0);
    check_val("idle_href", idle_href, 0);
    check_val("idle_fcnt", cap_fc, 4);

    // Frame 5: restart from IDLE with the flat mode requested mid frame 4.
    sel10  = 1'b0;
    enable = 1'b1;
    run_frame(-1, 1'b1, 2'b00, 2'b00);
    check_val("f5_gap", gap, 1);
    check_val("f5_r0x0", pix[0][0], 100);
    check_val("f5_r1x1", pix[1][1], 200);
    check_val("f5_fcnt", fc_end, 5);

    // Asynchronous reset in the middle of the first active line of frame 6.
    repeat (55) @(negedge clk);
    check_val("pre_rst_href", href8, 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_href", href8, 0);
    check_val("arst_vsync", vs8, 1);
    check_val("arst_hsync", hs8, 1);
    check_val("arst_raw", raw8, 0);
    check_val("arst_fcnt", fc8, 0);
    check_val("arst_busy", busy8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, 1'b1, 2'b00, 2'b00);
    check_val("post_rst_gap", gap, 1);
    check_val("post_rst_vs_low", vs_low, 22);
    check_val("post_rst_lines", lines_n, 4);
    check_val("post_rst_r0x0", pix[0][0], 100);
    check_val("post_rst_fcnt", fc_end, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
